cnt_job_sched: RTL and testbench

Round-robin scheduler that shares one `counter_ud` instance between `NREQ` requesters as a countdown timer. A granted requester supplies a length; the scheduler loads the counter, runs it down to zero, then pulses `done` back to that requester. The block sits between the requester agents and the counter's load and direction pins. The counter is reset by the same `rstn`.

---
 rtl/cnt_job_sched.sv | 110 +++++++++++
 tb/tb_cnt_job_sched.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/cnt_job_sched.sv
// Round-robin scheduler that time-shares one up/down counter as a countdown timer.
// A granted requester's length is loaded, counted down to zero, then acknowledged with done.
module cnt_job_sched #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned NREQ  = 4
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] req_len,
   output logic [NREQ-1:0]       gnt,
   output logic [NREQ-1:0]       done,
   output logic                  busy,
   output logic                  cnt_load_en,
   output logic [WIDTH-1:0]      cnt_load,
   output logic                  cnt_down,
   input  logic [WIDTH-1:0]      cnt_count
);
   localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_e;

   state_e           state_q, state_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [IW-1:0]    ptr_q, ptr_d;
   logic [WIDTH-1:0] len_q, len_d;

   logic [WIDTH-1:0] len_arr [NREQ];
   logic             win_vld;
   logic [IW-1:0]    win_idx;
   logic [IW-1:0]    cand;

   for (genvar g = 0; g < NREQ; g++) begin : g_len
      assign len_arr[g] = req_len[g*WIDTH +: WIDTH];
   end

   // First pending requester at or after ptr_q, wrapping modulo NREQ.
   always_comb begin
      win_vld = 1'b0;
      win_idx = '0;
      cand    = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         cand = IW'((32'(ptr_q) + k) % NREQ);
         if (!win_vld && req[cand]) begin
            win_vld = 1'b1;
            win_idx = cand;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         ptr_q   <= '0;
         len_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         ptr_q   <= ptr_d;
         len_q   <= len_d;
      end
   end

   // Next state plus output decode; outside a running job the counter is parked at zero.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      ptr_d       = ptr_q;
      len_d       = len_q;
      gnt         = '0;
      done        = '0;
      busy        = 1'b1;
      cnt_load_en = 1'b1;
      cnt_load    = '0;
      cnt_down    = 1'b0;
      case (state_q)
         S_IDLE: begin
            busy = 1'b0;
            if (win_vld) begin
               idx_d   = win_idx;
               len_d   = len_arr[win_idx];
               ptr_d   = IW'((32'(win_idx) + 32'd1) % NREQ);
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            gnt[idx_q] = 1'b1;
            cnt_load   = len_q;
            state_d    = S_RUN;
         end
         S_RUN: begin
            gnt[idx_q] = 1'b1;
            cnt_down   = 1'b1;
            // Reload zero at the bottom so the counter never wraps to all-ones.
            if (cnt_count != '0) begin
               cnt_load_en = 1'b0;
            end else begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            gnt[idx_q]  = 1'b1;
            done[idx_q] = 1'b1;
            state_d     = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end
endmodule

// File: tb/tb_cnt_job_sched.sv
// Bench for cnt_job_sched: requester agents, a counter_ud model, a job-level reference
// model feeding a queue of expected jobs, and a per-cycle monitor scoring the DUT.
module tb_cnt_job_sched;
   localparam int WIDTH = 4;
   localparam int NREQ  = 4;

   logic                  clk  = 1'b0;
   logic                  rstn = 1'b1;
   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] req_len;
   logic [NREQ-1:0]       gnt;
   logic [NREQ-1:0]       done;
   logic                  busy;
   logic                  cnt_load_en;
   logic [WIDTH-1:0]      cnt_load;
   logic                  cnt_down;
   logic [WIDTH-1:0]      cnt_count;

   bit rq     [NREQ];
   int rl     [NREQ];
   bit gnt_a  [NREQ];

   typedef struct {
      int idx;
      int len;
      int start;
   } job_t;

   job_t jobs[$];
   int   cyc       = 0;
   int   free_at   = 0;
   int   m_ptr     = 0;
   int   checks    = 0;
   int   errors    = 0;
   int   jobs_done = 0;
   bit   rnd_mode  = 1'b0;

   always #5 clk = ~clk;

   cnt_job_sched #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
      .clk         (clk),
      .rstn        (rstn),
      .req         (req),
      .req_len     (req_len),
      .gnt         (gnt),
      .done        (done),
      .busy        (busy),
      .cnt_load_en (cnt_load_en),
      .cnt_load    (cnt_load),
      .cnt_down    (cnt_down),
      .cnt_count   (cnt_count)
   );

   for (genvar g = 0; g < NREQ; g++) begin : g_pack
      assign req[g]                     = rq[g];
      assign req_len[g*WIDTH +: WIDTH]  = WIDTH'(rl[g]);
      assign gnt_a[g]                   = gnt[g];
   end

   // counter_ud: loads when load_en, otherwise steps every cycle in the selected direction.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)            cnt_count <= '0;
      else if (cnt_load_en) cnt_count <= cnt_load;
      else if (cnt_down)    cnt_count <= cnt_count - 1'b1;
      else                  cnt_count <= cnt_count + 1'b1;
   end

   function automatic void chk(string nm, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0h want %0h", nm, cyc, act, exp);
      end
   endfunction

   // Reference model: a job occupies len+4 cycles starting at its arbitration cycle.
   always @(posedge clk) begin : model
      int   w;
      int   c;
      job_t j;
      if (!rstn) begin
         jobs.delete();
         m_ptr   = 0;
         free_at = 0;
      end else if (cyc >= free_at) begin
         w = -1;
         for (int k = 0; k < NREQ; k++) begin
            c = (m_ptr + k) % NREQ;
            if (w < 0 && rq[c]) w = c;
         end
         if (w >= 0) begin
            j.idx   = w;
            j.len   = rl[w];
            j.start = cyc;
            jobs.push_back(j);
            m_ptr   = (w + 1) % NREQ;
            free_at = cyc + 4 + rl[w];
         end
      end
      cyc = cyc + 1;
   end

   // Monitor: derive every output from the front job's age and compare.
   always @(negedge clk) begin : mon
      int e_gnt, e_done, e_busy, e_le, e_ld, e_dn, e_cnt, d, ln;
      bit pop;
      e_gnt = 0; e_done = 0; e_busy = 0; e_le = 1; e_ld = 0; e_dn = 0; e_cnt = 0;
      pop = 1'b0;
      if (rstn && jobs.size() > 0) begin
         d  = cyc - jobs[0].start;
         ln = jobs[0].len;
         if (d >= 1) begin
            e_busy = 1;
            e_gnt  = 1 << jobs[0].idx;
         end
         if (d == 1) begin
            e_ld = ln;
         end else if (d >= 2 && d <= 2 + ln) begin
            e_dn  = 1;
            e_cnt = ln - (d - 2);
            e_le  = (e_cnt == 0) ? 1 : 0;
         end else if (d == 3 + ln) begin
            e_done = 1 << jobs[0].idx;
            pop    = 1'b1;
         end
      end
      chk("gnt",         32'(gnt),         e_gnt);
      chk("done",        32'(done),        e_done);
      chk("busy",        32'(busy),        e_busy);
      chk("cnt_load_en", 32'(cnt_load_en), e_le);
      chk("cnt_load",    32'(cnt_load),    e_ld);
      chk("cnt_down",    32'(cnt_down),    e_dn);
      chk("cnt_count",   32'(cnt_count),   e_cnt);
      if (pop) begin
         void'(jobs.pop_front());
         jobs_done++;
      end
   end

   function automatic int pick_len();
      case ($urandom_range(0, 7))
         0:       return 0;
         1:       return (1 << WIDTH) - 1;
         default: return int'($urandom_range(0, 6));
      endcase
   endfunction

   // Agents drop req on seeing their grant; in random mode idle agents raise new jobs.
   task automatic tick();
      @(negedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
         if (rq[i] && gnt_a[i]) begin
            rq[i] = 1'b0;
         end else if (rnd_mode && !rq[i] && $urandom_range(0, 5) == 0) begin
            rl[i] = pick_len();
            rq[i] = 1'b1;
         end
      end
   endtask

   task automatic run(input int n);
      repeat (n) tick();
   endtask

   task automatic raise(input int i, input int len);
      rl[i] = len;
      rq[i] = 1'b1;
   endtask

   task automatic wait_gnt(input int i, input int bound);
      int n;
      n = 0;
      while (!gnt_a[i] && n < bound) begin
         tick();
         n++;
      end
      chk($sformatf("wait_gnt%0d", i), 32'(gnt_a[i]), 1);
   endtask

   initial begin
      for (int i = 0; i < NREQ; i++) begin
         rq[i] = 1'b0;
         rl[i] = 0;
      end
      #1 rstn = 1'b0;
      for (int i = 0; i < NREQ; i++) raise(i, 2);
      run(3);
      rstn = 1'b1;
      // Contention: 0,1,2,3 in order, then the re-raised requester 0.
      wait_gnt(1, 20);
      raise(0, 2);
      run(40);
      raise(1, 3);
      run(12);
      raise(2, 0);
      run(8);
      raise(0, (1 << WIDTH) - 1);
      run(24);
      // Reset in the middle of a long job.
      raise(3, 10);
      wait_gnt(3, 10);
      run(3);
      rstn = 1'b0;
      #1;
      chk("rst_gnt",  32'(gnt),         0);
      chk("rst_busy", 32'(busy),        0);
      chk("rst_le",   32'(cnt_load_en), 1);
      chk("rst_done", 32'(done),        0);
      raise(1, 5);
      raise(3, 4);
      run(2);
      rstn = 1'b1;
      wait_gnt(1, 4);
      chk("rr_after_rst", 32'(gnt), 2);
      run(30);
      rnd_mode = 1'b1;
      run(3000);
      rnd_mode = 1'b0;
      run(120);
      chk("drain_jobs", jobs.size(), 0);
      chk("drain_req",  32'(req),    0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
